// File: rtl/spi_slave_if_if.sv
// SPI pin-side and RAM-side signal bundle for the SPI slave front-end.
interface spi_slave_if_if #(
  parameter int FRAME_W   = 10,
  parameter int ADDR_SIZE = 8
);
  logic                 SS_n;
  logic                 MOSI;
  logic                 MISO;
  logic [FRAME_W-1:0]   rx_data;
  logic                 rx_valid;
  logic [ADDR_SIZE-1:0] tx_data;
  logic                 tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output rx_data, rx_valid, MISO
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  rx_data, rx_valid, MISO
  );
endinterface

// File: rtl/spi_slave_if.sv
// SPI slave front-end: deserialises MOSI frames into RAM command/data words
// and serialises the RAM read byte back onto MISO, all in the SPI clock domain.
module spi_slave_if #(
  parameter int FRAME_W   = 10,
  parameter int ADDR_SIZE = 8
) (
  input logic           clk,
  input logic           rst,
  spi_slave_if_if.slave bus
);

  localparam int CNT_W = $clog2(FRAME_W + 1);
  localparam int TXC_W = $clog2(ADDR_SIZE);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [FRAME_W-2:0]   shreg;
  logic [FRAME_W-1:0]   frame_next;
  logic [FRAME_W-1:0]   rx_data_q;
  logic                 rx_valid_q;
  logic [ADDR_SIZE-1:0] tx_buf;
  logic [TXC_W-1:0]     tx_cnt;
  logic                 miso_q;
  logic                 rd_addr_done;
  logic                 wait_tx;

  always_comb begin
    frame_next = {shreg, bus.MOSI};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      tx_buf       <= '0;
      tx_cnt       <= '0;
      miso_q       <= 1'b0;
      rd_addr_done <= 1'b0;
      wait_tx      <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (bus.SS_n) begin
        // Frame abandoned or finished: rd_addr_done survives so that a read
        // address frame can be followed by a separate read data frame.
        state   <= IDLE;
        bit_cnt <= '0;
        shreg   <= '0;
        tx_buf  <= '0;
        tx_cnt  <= '0;
        miso_q  <= 1'b0;
        wait_tx <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= CHK_CMD;
          CHK_CMD: begin
            shreg   <= frame_next[FRAME_W-2:0];
            bit_cnt <= CNT_W'(1);
            if (!bus.MOSI)         state <= WRITE;
            else if (rd_addr_done) state <= READ_DATA;
            else                   state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            // Counter parks at FRAME_W; extra MOSI bits are ignored.
            if (bit_cnt != CNT_W'(FRAME_W)) begin
              shreg   <= frame_next[FRAME_W-2:0];
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == CNT_W'(FRAME_W - 1)) begin
                rx_data_q  <= frame_next;
                rx_valid_q <= 1'b1;
                if (state == READ_ADD) rd_addr_done <= 1'b1;
                if (state == READ_DATA) begin
                  rd_addr_done <= 1'b0;
                  wait_tx      <= 1'b1;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase

        // tx_cnt counts bits still to follow the one currently on MISO.
        if (wait_tx && bus.tx_valid) begin
          miso_q  <= bus.tx_data[ADDR_SIZE-1];
          tx_buf  <= {bus.tx_data[ADDR_SIZE-2:0], 1'b0};
          tx_cnt  <= TXC_W'(ADDR_SIZE - 1);
          wait_tx <= 1'b0;
        end else if (tx_cnt != '0) begin
          miso_q <= tx_buf[ADDR_SIZE-1];
          tx_buf <= {tx_buf[ADDR_SIZE-2:0], 1'b0};
          tx_cnt <= tx_cnt - 1'b1;
        end else begin
          miso_q <= 1'b0;
        end
      end
    end
  end

  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.MISO     = miso_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Randomised frame-level bench for spi_slave_if against a behavioural model.
module tb_spi_slave_if;

  logic clk;
  logic rst;

  spi_slave_if_if #(.FRAME_W(10), .ADDR_SIZE(8)) bus ();

  spi_slave_if #(.FRAME_W(10), .ADDR_SIZE(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Model state: last delivered word, read-address flag, pending read-back.
  logic [9:0] m_rx;
  bit         m_rd;
  bit         m_wait;
  bit         m_miso[$];

  bit         ram_hold;
  bit         stale_en;
  bit         tx_fixed_en;
  logic [7:0] tx_fixed;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_edge(input bit ssn, input bit txv, input logic [7:0] txd,
                            input bit done, input logic [9:0] word,
                            output bit e_rv, output bit e_miso);
    e_rv   = 1'b0;
    e_miso = 1'b0;
    if (ssn) begin
      m_miso.delete();
      m_wait = 1'b0;
    end else begin
      e_rv = done;
      if (m_wait && txv) begin
        m_wait = 1'b0;
        m_miso.delete();
        for (int i = 7; i >= 0; i--) m_miso.push_back(txd[i]);
      end
      if (m_miso.size() != 0) e_miso = m_miso.pop_front();
      if (done) begin
        m_rx = word;
        if (word[9]) begin
          if (m_rd) begin
            m_rd   = 1'b0;
            m_wait = 1'b1;
          end else begin
            m_rd = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic cyc(input bit ssn, input bit mosi, input bit done, input logic [9:0] word);
    logic [7:0] txd;
    bit         txv;
    bit         e_rv;
    bit         e_miso;
    txd = tx_fixed_en ? tx_fixed : 8'($urandom());
    txv = stale_en | ram_hold;
    bus.SS_n     = ssn;
    bus.MOSI     = mosi;
    bus.tx_valid = txv;
    bus.tx_data  = txd;
    model_edge(ssn, txv, txd, done, word, e_rv, e_miso);
    step();
    check("rx_valid", 32'(bus.rx_valid), 32'(e_rv));
    check("rx_data", 32'(bus.rx_data), 32'(m_rx));
    check("miso", 32'(bus.MISO), 32'(e_miso));
    // RAM side: a read-data command makes the RAM present its byte and hold valid.
    if (bus.rx_valid && bus.rx_data[9:8] == 2'b11) ram_hold = 1'b1;
  endtask

  // nbits < 10 raises SS_n while the next frame bit is on MOSI.
  task automatic frame(input logic [9:0] w, input int unsigned nbits, input int unsigned tail);
    ram_hold = 1'b0;
    cyc(1'b0, 1'($urandom()), 1'b0, w);
    for (int unsigned k = 1; k <= nbits; k++) cyc(1'b0, w[10-k], (k == 10), w);
    if (nbits == 10) begin
      for (int unsigned t = 0; t < tail; t++) cyc(1'b0, 1'($urandom()), 1'b0, w);
      cyc(1'b1, 1'($urandom()), 1'b0, w);
    end else begin
      cyc(1'b1, w[9-nbits], 1'b0, w);
    end
    ram_hold = 1'b0;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.SS_n    = 1'b0;
    bus.MOSI    = 1'($urandom());
    step();
    m_rx   = '0;
    m_rd   = 1'b0;
    m_wait = 1'b0;
    m_miso.delete();
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_miso", 32'(bus.MISO), 32'd0);
    check("rst_rx_data", 32'(bus.rx_data), 32'd0);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 10'h000);
  endtask

  initial begin
    logic [9:0] w;
    rst          = 1'b1;
    bus.SS_n     = 1'b1;
    bus.MOSI     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    ram_hold     = 1'b0;
    stale_en     = 1'b0;
    tx_fixed_en  = 1'b0;
    tx_fixed     = '0;
    m_rx         = '0;
    m_rd         = 1'b0;
    m_wait       = 1'b0;
    step();
    step();
    check("init_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("init_rx_data", 32'(bus.rx_data), 32'd0);
    check("init_miso", 32'(bus.MISO), 32'd0);
    rst = 1'b0;

    frame(10'h0A5, 10, 2);
    frame(10'h13C, 10, 2);
    frame(10'h2A5, 10, 2);
    tx_fixed_en = 1'b1;
    tx_fixed    = 8'h3C;
    frame(10'h35A, 10, 12);
    tx_fixed_en = 1'b0;

    frame(10'h0FF, 5, 0);
    frame(10'h055, 10, 1);

    stale_en = 1'b1;
    frame(10'h1C3, 10, 10);
    stale_en = 1'b0;

    frame(10'h2AA, 9, 0);
    frame(10'h0C3, 10, 0);

    // Reset mid-frame after a read address must forget rd_addr_done.
    frame(10'h211, 10, 1);
    cyc(1'b0, 1'b0, 1'b0, 10'h000);
    cyc(1'b0, 1'b1, 1'b0, 10'h000);
    cyc(1'b0, 1'b1, 1'b0, 10'h000);
    do_reset();
    frame(10'h3E7, 10, 12);
    frame(10'h3E8, 10, 12);

    for (int n = 0; n < 60; n++) begin
      w        = 10'($urandom());
      stale_en = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) frame(w, $urandom_range(0, 9), 0);
      else                           frame(w, 10, $urandom_range(0, 12));
    end
    stale_en = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 10'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
